// File: rtl/pc_ncl_issue.sv
// Program-counter issue stage: launches each PC as a dual-rail NCL DATA wavefront
// followed by NULL, handshaking on a synchronised ack from the downstream stage.
module pc_ncl_issue #(
   parameter int unsigned           ADDR_BITS   = 4,
   parameter logic [ADDR_BITS-1:0]  RESET_ADDR  = '0,
   parameter int unsigned           SYNC_STAGES = 2,
   parameter int unsigned           TIMEOUT     = 255
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   run,
   input  logic                   jmp_valid,
   input  logic [ADDR_BITS-1:0]   jmp_addr,
   output logic                   jmp_ready,
   output logic [2*ADDR_BITS-1:0] PC_addr_out,
   output logic [1:0]             PH0_out,
   input  logic                   ack_in,
   output logic [ADDR_BITS-1:0]   pc_value,
   output logic                   busy,
   output logic                   timeout_err
);

   localparam int unsigned NSYNC = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
   localparam int unsigned CW    = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] TMAX = CW'(TIMEOUT);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_DATA,
      ST_NULL
   } state_t;

   state_t                 state_q, state_nxt;
   logic [NSYNC-1:0]       sync_q;
   logic                   ack_s;

   logic [ADDR_BITS-1:0]   pc_q, pc_nxt;
   logic [2*ADDR_BITS-1:0] addr_q, addr_nxt;
   logic [1:0]             ph0_q, ph0_nxt;
   logic                   busy_q, busy_nxt;
   logic                   jr_q, jr_nxt;
   logic                   first_q, first_nxt;
   logic [CW-1:0]          cnt_q, cnt_nxt, cnt_inc;
   logic                   err_q, err_nxt;
   logic                   entering;
   logic [ADDR_BITS-1:0]   launch_pc;

   function automatic logic [2*ADDR_BITS-1:0] dual_rail(input logic [ADDR_BITS-1:0] v);
      logic [2*ADDR_BITS-1:0] r;
      r = '0;
      for (int unsigned i = 0; i < ADDR_BITS; i++) begin
         r[2*i+1] = v[i];
         r[2*i]   = ~v[i];
      end
      return r;
   endfunction

   // ack_in is asynchronous; only the last synchroniser flop feeds decisions
   always_ff @(posedge clk) begin
      if (!rst_n) sync_q <= '0;
      else        sync_q <= {sync_q[NSYNC-2:0], ack_in};
   end

   assign ack_s = sync_q[NSYNC-1];

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         pc_q    <= RESET_ADDR;
         addr_q  <= '0;
         ph0_q   <= '0;
         busy_q  <= 1'b0;
         jr_q    <= 1'b0;
         first_q <= 1'b1;
         cnt_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_nxt;
         pc_q    <= pc_nxt;
         addr_q  <= addr_nxt;
         ph0_q   <= ph0_nxt;
         busy_q  <= busy_nxt;
         jr_q    <= jr_nxt;
         first_q <= first_nxt;
         cnt_q   <= cnt_nxt;
         err_q   <= err_nxt;
      end
   end

   always_comb begin
      state_nxt = state_q;
      case (state_q)
         ST_IDLE: if (run && !ack_s) state_nxt = ST_DATA;
         ST_DATA: if (ack_s)         state_nxt = ST_NULL;
         ST_NULL: if (!ack_s)        state_nxt = ST_IDLE;
         default:                    state_nxt = ST_IDLE;
      endcase
   end

   // Computes the next value of every registered output from the current transition
   always_comb begin
      pc_nxt    = pc_q;
      addr_nxt  = addr_q;
      ph0_nxt   = ph0_q;
      busy_nxt  = busy_q;
      jr_nxt    = 1'b0;
      first_nxt = first_q;
      cnt_nxt   = cnt_q;
      err_nxt   = err_q;
      entering  = (state_nxt != state_q);
      cnt_inc   = cnt_q + CW'(1);
      launch_pc = jmp_valid ? jmp_addr : pc_q;

      // Counter saturates at TMAX so the flag fires exactly once per wait
      if (entering) begin
         cnt_nxt = '0;
      end else if (state_q != ST_IDLE && cnt_q != TMAX) begin
         cnt_nxt = cnt_inc;
         if (TIMEOUT != 0 && cnt_inc == TMAX) err_nxt = 1'b1;
      end

      case (state_q)
         ST_IDLE: begin
            addr_nxt = '0;
            ph0_nxt  = '0;
            if (state_nxt == ST_DATA) begin
               pc_nxt   = launch_pc;
               addr_nxt = dual_rail(launch_pc);
               ph0_nxt  = (jmp_valid || first_q) ? 2'b10 : 2'b01;
               busy_nxt = 1'b1;
               if (jmp_valid) begin
                  jr_nxt    = 1'b1;
                  first_nxt = 1'b1;
               end
            end
         end
         ST_DATA: begin
            if (state_nxt == ST_NULL) begin
               addr_nxt  = '0;
               ph0_nxt   = '0;
               first_nxt = 1'b0;
            end
         end
         ST_NULL: begin
            addr_nxt = '0;
            ph0_nxt  = '0;
            if (state_nxt == ST_IDLE) begin
               pc_nxt   = pc_q + ADDR_BITS'(1);
               busy_nxt = 1'b0;
            end
         end
         default: begin
            addr_nxt = '0;
            ph0_nxt  = '0;
         end
      endcase
   end

   assign pc_value    = pc_q;
   assign PC_addr_out = addr_q;
   assign PH0_out     = ph0_q;
   assign busy        = busy_q;
   assign jmp_ready   = jr_q;
   assign timeout_err = err_q;

endmodule

// File: tb/tb_pc_ncl_issue.sv
// Directed bench for pc_ncl_issue: one instance with TIMEOUT=20, one with RESET_ADDR=15.
module tb_pc_ncl_issue;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       run, run_b;
   logic       jmp_valid;
   logic [3:0] jmp_addr;
   logic       ack_a, ack_b;
   logic       jmp_valid_b;
   logic [3:0] jmp_addr_b;

   logic       jr_a, jr_b;
   logic [7:0] addr_a, addr_b, prev_a, prev_b;
   logic [1:0] ph0_a, ph0_b;
   logic [3:0] pc_a, pc_b;
   logic       busy_a, busy_b, err_a, err_b;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   pc_ncl_issue #(.ADDR_BITS(4), .RESET_ADDR(4'd0), .SYNC_STAGES(2), .TIMEOUT(20)) dut (
      .clk(clk), .rst_n(rst_n), .run(run), .jmp_valid(jmp_valid), .jmp_addr(jmp_addr),
      .jmp_ready(jr_a), .PC_addr_out(addr_a), .PH0_out(ph0_a), .ack_in(ack_a),
      .pc_value(pc_a), .busy(busy_a), .timeout_err(err_a)
   );

   pc_ncl_issue #(.ADDR_BITS(4), .RESET_ADDR(4'd15), .SYNC_STAGES(2), .TIMEOUT(255)) dut_b (
      .clk(clk), .rst_n(rst_n), .run(run_b), .jmp_valid(jmp_valid_b), .jmp_addr(jmp_addr_b),
      .jmp_ready(jr_b), .PC_addr_out(addr_b), .PH0_out(ph0_b), .ack_in(ack_b),
      .pc_value(pc_b), .busy(busy_b), .timeout_err(err_b)
   );

   function automatic logic wave_ok(input logic [7:0] a);
      logic ok;
      ok = 1'b1;
      if (a != 8'h00)
         for (int i = 0; i < 4; i++)
            if ((a[2*i+1] ^ a[2*i]) !== 1'b1) ok = 1'b0;
      return ok;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Each cycle: rails must be NULL or a complete dual-rail word, and DATA never follows DATA
   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
         chk("wave_a", {31'd0, wave_ok(addr_a)}, 32'd1);
         chk("wave_b", {31'd0, wave_ok(addr_b)}, 32'd1);
         chk("d2d_a", {31'd0, (prev_a == 8'h00 || addr_a == 8'h00 || addr_a == prev_a)}, 32'd1);
         chk("d2d_b", {31'd0, (prev_b == 8'h00 || addr_b == 8'h00 || addr_b == prev_b)}, 32'd1);
         prev_a = addr_a;
         prev_b = addr_b;
      end
   endtask

   task automatic ack_hi();
      ack_a = 1'b1;
      step(3);
   endtask

   task automatic ack_lo();
      ack_a = 1'b0;
      step(3);
   endtask

   initial begin
      rst_n = 1'b0; run = 1'b0; run_b = 1'b0;
      jmp_valid = 1'b0; jmp_addr = 4'd0;
      jmp_valid_b = 1'b0; jmp_addr_b = 4'd0;
      ack_a = 1'b0; ack_b = 1'b0;
      prev_a = 8'h00; prev_b = 8'h00;
      step(2);

      // Reset state
      chk("rst_addr", addr_a, 8'h00);
      chk("rst_ph0", ph0_a, 2'b00);
      chk("rst_pc", pc_a, 4'd0);
      chk("rst_busy", busy_a, 1'b0);
      chk("rst_jr", jr_a, 1'b0);
      chk("rst_err", err_a, 1'b0);
      chk("rst_pc_b", pc_b, 4'd15);

      // Test 1: first launch and sequential advance
      rst_n = 1'b1; run = 1'b1;
      step(1);
      chk("t1_addr0", addr_a, 8'b01010101);
      chk("t1_ph0_0", ph0_a, 2'b10);
      chk("t1_pc0", pc_a, 4'd0);
      chk("t1_busy", busy_a, 1'b1);
      ack_a = 1'b1;
      step(2);
      chk("t1_hold", addr_a, 8'b01010101);
      step(1);
      chk("t1_null", addr_a, 8'h00);
      chk("t1_null_ph0", ph0_a, 2'b00);
      chk("t1_null_busy", busy_a, 1'b1);
      ack_lo();
      chk("t1_idle_pc", pc_a, 4'd1);
      chk("t1_idle_busy", busy_a, 1'b0);
      step(1);
      chk("t1_addr1", addr_a, 8'b01010110);
      chk("t1_ph0_1", ph0_a, 2'b01);

      // Test 3: jump requested during DATA of PC=2
      ack_hi();
      ack_lo();
      step(1);
      chk("t3_addr2", addr_a, 8'b01011001);
      chk("t3_pc2", pc_a, 4'd2);
      jmp_valid = 1'b1; jmp_addr = 4'd9;
      step(1);
      chk("t3_jr_data", jr_a, 1'b0);
      ack_hi();
      chk("t3_jr_null", jr_a, 1'b0);
      ack_lo();
      chk("t3_jr_idle", jr_a, 1'b0);
      chk("t3_pc_inc", pc_a, 4'd3);
      step(1);
      chk("t3_jr_pulse", jr_a, 1'b1);
      chk("t3_addr9", addr_a, 8'b10010110);
      chk("t3_ph0", ph0_a, 2'b10);
      chk("t3_pc9", pc_a, 4'd9);
      jmp_valid = 1'b0;
      step(1);
      chk("t3_jr_low", jr_a, 1'b0);

      // Test 4: run dropped mid-DATA
      run = 1'b0;
      ack_hi();
      chk("t4_null", addr_a, 8'h00);
      ack_lo();
      chk("t4_busy", busy_a, 1'b0);
      chk("t4_pc", pc_a, 4'd10);
      step(3);
      chk("t4_nolaunch", addr_a, 8'h00);
      chk("t4_nobusy", busy_a, 1'b0);
      run = 1'b1;
      step(1);
      chk("t4_resume", addr_a, 8'b10011001);
      chk("t4_ph0", ph0_a, 2'b01);

      // Test 5: timeout with ack held low, 20 cycles after DATA entry
      step(19);
      chk("t5_err_19", err_a, 1'b0);
      step(1);
      chk("t5_err_20", err_a, 1'b1);
      step(5);
      chk("t5_sticky", err_a, 1'b1);
      chk("t5_wait", addr_a, 8'b10011001);
      ack_hi();
      chk("t5_null", addr_a, 8'h00);
      ack_lo();
      chk("t5_pc", pc_a, 4'd11);
      chk("t5_err_kept", err_a, 1'b1);

      // Test 6: reset during DATA
      step(1);
      chk("t6_addr11", addr_a, 8'b10011010);
      rst_n = 1'b0;
      step(1);
      chk("t6_addr", addr_a, 8'h00);
      chk("t6_ph0", ph0_a, 2'b00);
      chk("t6_pc", pc_a, 4'd0);
      chk("t6_err", err_a, 1'b0);
      chk("t6_busy", busy_a, 1'b0);
      rst_n = 1'b1;
      step(1);
      chk("t6_relaunch", addr_a, 8'b01010101);
      chk("t6_ph0_first", ph0_a, 2'b10);

      // Stale ack in IDLE holds off the launch
      run = 1'b0;
      ack_hi();
      ack_lo();
      chk("st_pc", pc_a, 4'd1);
      ack_a = 1'b1;
      step(3);
      run = 1'b1;
      step(3);
      chk("st_wait_busy", busy_a, 1'b0);
      chk("st_wait_addr", addr_a, 8'h00);
      ack_a = 1'b0;
      step(2);
      chk("st_still_idle", busy_a, 1'b0);
      step(1);
      chk("st_launch", addr_a, 8'b01010110);
      chk("st_ph0", ph0_a, 2'b01);

      // Test 2: RESET_ADDR=15 wraps through 0 and 1
      run_b = 1'b1;
      step(1);
      chk("t2_addr15", addr_b, 8'b10101010);
      chk("t2_ph0_15", ph0_b, 2'b10);
      chk("t2_pc15", pc_b, 4'd15);
      ack_b = 1'b1;
      step(3);
      chk("t2_null", addr_b, 8'h00);
      ack_b = 1'b0;
      step(3);
      chk("t2_wrap", pc_b, 4'd0);
      step(1);
      chk("t2_addr0", addr_b, 8'b01010101);
      chk("t2_ph0_0", ph0_b, 2'b01);
      ack_b = 1'b1;
      step(3);
      ack_b = 1'b0;
      step(4);
      chk("t2_addr1", addr_b, 8'b01010110);
      chk("t2_pc1", pc_b, 4'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/pc_ncl_issue.md
Name: pc_ncl_issue

Overview:
Clocked program-counter stage that sits directly upstream of the address-enable stage. It holds a binary PC and launches each address as a dual-rail NCL wavefront. A DATA wavefront carries PC_addr plus a PH0 marker; the stage then drives a NULL wavefront, completing a 4-phase handshake on ack_in from the downstream stage. It advances the PC sequentially and accepts jump requests from control logic.

Parameters:
ADDR_BITS, 4, binary PC width; dual-rail bus is 2*ADDR_BITS wide.
RESET_ADDR, 0, PC value loaded at reset.
SYNC_STAGES, 2, flops in the ack_in synchroniser (minimum 2).
TIMEOUT, 255, cycles waited for an ack edge before timeout_err is set; 0 disables the check.

Ports:
clk  input  1  clock
rst_n  input  1  reset; synchronous, active-low
run  input  1  high allows new fetches to launch
jmp_valid  input  1  jump request
jmp_addr  input  ADDR_BITS  jump target, binary
jmp_ready  output  1  one-cycle pulse when the jump is accepted
PC_addr_out  output  2*ADDR_BITS  dual-rail address; bit 2i+1 = true rail of bit i, bit 2i = false rail
PH0_out  output  2  dual-rail phase-0 marker; [1] = true rail, [0] = false rail
ack_in  input  1  asynchronous ack from downstream; high = DATA captured, low = NULL captured
pc_value  output  ADDR_BITS  binary PC of the current or next fetch
busy  output  1  high while a wavefront is outstanding
timeout_err  output  1  sticky timeout flag

Behaviour:
- Reset applies while rst_n is low at a clk edge:
  - state=IDLE; PC_addr_out=0 and PH0_out=0 (NULL).
  - pc_value=RESET_ADDR; busy=0; jmp_ready=0; timeout_err=0.
  - Synchroniser flops cleared; first_flag=1.
- ack_in passes through SYNC_STAGES flops, giving ack_s. All decisions use ack_s only. All outputs are registered.
- IDLE:
  - Outputs are NULL.
  - If run=1 and ack_s=0, go to DATA at the next edge.
  - At that edge, if jmp_valid=1: pc_value←jmp_addr, jmp_ready pulses for 1 cycle, first_flag←1. The launched address is jmp_addr.
- DATA:
  - On entry, PC_addr_out is the dual-rail encoding of the launch PC (exactly one rail high per bit).
  - PH0_out=10 if first_flag=1, else 01. busy=1.
  - Stay until ack_s=1, then go to NULL at the next edge.
- NULL:
  - On entry, PC_addr_out=0 and PH0_out=00. first_flag←0.
  - Stay until ack_s=0. Then go to IDLE at the next edge and set pc_value←pc_value+1, modulo 2^ADDR_BITS (the maximum value wraps to 0).
  - busy drops on entry to IDLE.
- Output rails never transition directly from one DATA value to another. Every DATA is separated by NULL.
- Jumps:
  - jmp_valid is sampled only on the IDLE→DATA edge. In other states it is held pending (not dropped) and jmp_ready stays low.
  - A jump overrides the sequential increment already applied.
- run=0 blocks only new launches. An outstanding DATA/NULL wavefront always completes.
- Timeout:
  - A counter resets on every state entry and increments in DATA and NULL.
  - When it reaches TIMEOUT, timeout_err←1 (sticky until reset). The state machine keeps waiting; there is no forced recovery.
- Reset mid-wavefront forces NULL on the next edge. The downstream is expected to return ack to 0 before the first launch.
- If ack_s=1 in IDLE (stale ack), the launch waits.
- Throughput: minimum 3 + 2*SYNC_STAGES cycles per fetch with an ideal downstream.

Test Plan:
1. Reset, run=1, downstream model ack = OR of the rails after 2 cycles. Expected: first DATA has pc_value=0, PC_addr_out=8'b01010101, PH0_out=10. Next DATA is 8'b01010110 with PH0_out=01, and NULL (8'h00) appears between them.
2. RESET_ADDR=15, free-running. Expected sequence 15 (8'b10101010), then 0, then 1; no spurious rail pairs of 11.
3. jmp_valid=1 with jmp_addr=9 asserted during DATA of PC=2. Expected: no jmp_ready until the next IDLE→DATA edge. Then jmp_ready pulses for 1 cycle, the launch is 8'b10010110, and PH0_out=10.
4. Drop run mid-DATA. Expected: the wavefront completes through NULL, busy=0, and no further launch. Raising run resumes at the incremented PC.
5. ack_in held low after DATA, TIMEOUT=20. Expected: timeout_err rises exactly 20 cycles after DATA entry and stays high. Asserting ack then completes the wavefront normally.
6. rst_n low for 1 edge while in DATA. Expected: outputs NULL and pc_value=RESET_ADDR on that edge, timeout_err=0.
